spi_target: RTL and testbench
=============================

// Module: spi_target
// PURPOSE
// - SPI mode-0 responder (target) matching the board's bit-banged SPI initiator (SCK, MOSI, nSS[1:0]).
// - Answers one nSS line: shifts MOSI into received bytes and serves queued transmit bytes on MISO.
// - Used as a loop-back/debug peripheral and as an SPI device model in board-level simulation.
// - All pin inputs are asynchronous and oversampled by CLK, which must be much faster than SCK.
// PARAMETERS
// - SYNC_STAGES  2      flip-flop stages on the SCK, nSS and MOSI synchronisers (>=2)
// - IDLE_BYTE    8'hFF  byte shifted out when no transmit byte is queued
// PORTS
// - CLK         in   1  system clock; all state changes on posedge
// - RST         in   1  asynchronous, active-high reset
// - SCK         in   1  SPI clock from the initiator (CPOL=0)
// - nSS         in   1  active-low select
// - MOSI        in   1  initiator data, MSB first
// - MISO        out  1  target data, MSB first
// - MISO_OE     out  1  1 while selected (tri-state enable for pad)
// - TX_DATA     in   8  next byte to send
// - TX_VALID    in   1  TX_DATA valid
// - TX_READY    out  1  one-deep holding register empty
// - TX_UNDERRUN out  1  1-cycle pulse: a byte slot began with the holding register empty
// - RX_DATA     out  8  last received byte
// - RX_VALID    out  1  RX_DATA held until consumed
// - RX_READY    in   1  consumer accepts RX_DATA when RX_VALID&&RX_READY
// - RX_OVERRUN  out  1  sticky: byte completed while RX_VALID&&!RX_READY
// - OVR_CLR     in   1  clears RX_OVERRUN
// - BUSY        out  1  selected and bit count != 0
// BEHAVIOUR
// - Reset: MISO=0, MISO_OE=0, TX_READY=1, TX_UNDERRUN=0, RX_DATA=0, RX_VALID=0, RX_OVERRUN=0, BUSY=0.
// - Reset also sets the synchronised SCK to 0 and nSS to 1 and the bit count to 0.
// - Pin events are detected as edges of the synchronised signals.
// - Latency from a pin edge to the internal event is SYNC_STAGES+1 CLK.
// - SCK high and low phases must each be >= SYNC_STAGES+2 CLK; shorter phases are out of spec.
// - States: IDLE (nSS high) and SHIFT (bit count 0..7).
// - nSS falls: enter SHIFT with count=0 and load tx_shift.
//   - The load takes the holding register if full (and empties it), else IDLE_BYTE with a TX_UNDERRUN pulse.
//   - MISO_OE=1 and MISO=tx_shift[7] from the same cycle.
// - SCK rising, in SHIFT: rx_shift <= {rx_shift[6:0],MOSI}; count++.
// - SCK falling, in SHIFT, count in 1..7: tx_shift <= tx_shift<<1; MISO follows tx_shift[7].
// - Byte completes when the 8th rising edge is seen (count wraps 7->0 that cycle).
//   - The full byte goes to RX_DATA and RX_VALID=1, if RX_VALID==0 or RX_READY==1 in that cycle.
//   - Otherwise RX_DATA is unchanged, the byte is dropped and RX_OVERRUN=1.
// - The next falling edge with count==0 reloads tx_shift by the nSS-fall rule.
//   - This gives back-to-back bytes with no gap.
// - RX_VALID clears on RX_VALID&&RX_READY unless a new byte lands in the same cycle; then it stays 1 with the new data.
// - TX_READY is the inverse of holding-register-full; the holding register loads on TX_VALID&&TX_READY.
// - If a load and a tx_shift reload fall in the same cycle, the reload sees the old (empty) state: IDLE_BYTE is sent with an underrun pulse, and the new byte waits.
// - OVR_CLR and a new overrun in the same cycle leave RX_OVERRUN=1.
// - nSS rises mid-byte: abort to IDLE with count=0, the partial rx byte discarded and MISO_OE=0.
//   - The holding register and RX state are preserved.
// - SCK edges are ignored while nSS is high.
// - RST asserted mid-transfer returns everything to reset values immediately, including the holding register.
// STRUCTURE
// - Shared package gt_spi_pkg holds SPI_BITS=8, the default IDLE_BYTE and a 2-value state enum (ST_IDLE, ST_SHIFT).
// - One sub-module, spi_pin_sync: a SYNC_STAGES synchroniser with rise/fall pulse outputs.
//   - It is instantiated for SCK and nSS; MOSI uses the synchroniser only.
// - Everything else is flat: the FSM, 3-bit counter, two shift registers, holding register and RX register.
// TESTING
// - Queue 8'hA5, select, clock 8 bits with MOSI=8'h3C -> MISO bits 1,0,1,0,0,1,0,1; RX_DATA=8'h3C; RX_VALID=1; no underrun.
// - Select with an empty queue -> MISO = 8'hFF, TX_UNDERRUN pulses once; queue 8'h12 mid-byte -> the next byte sends 8'h12.
// - Two back-to-back bytes 8'h01, 8'h02 with RX_READY=0 -> RX_DATA=8'h01, RX_OVERRUN=1; OVR_CLR -> 0.
// - Deassert nSS after 5 SCK rises -> RX_VALID unchanged, BUSY=0, MISO_OE=0; the next transfer starts at bit 7 cleanly.
// - Assert RST mid-byte with the holding register full -> all outputs at reset values, TX_READY=1.
// - Half-period sweep at exactly SYNC_STAGES+2 CLK with a random 64-byte stream -> bit-exact match both directions.

Source files
------------

// File: rtl/gt_spi_pkg.sv
// rtl/gt_spi_pkg.sv - shared constants and state type for the SPI target
package gt_spi_pkg;
    localparam int SPI_BITS = 8;
    localparam logic [SPI_BITS-1:0] IDLE_BYTE_DEFAULT = 8'hFF;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } spi_state_t;
endpackage

// File: rtl/spi_target_if.sv
// rtl/spi_target_if.sv - pin and byte-stream signals of the SPI target
interface spi_target_if;
    import gt_spi_pkg::*;

    logic                SCK;
    logic                nSS;
    logic                MOSI;
    logic                MISO;
    logic                MISO_OE;
    logic [SPI_BITS-1:0] TX_DATA;
    logic                TX_VALID;
    logic                TX_READY;
    logic                TX_UNDERRUN;
    logic [SPI_BITS-1:0] RX_DATA;
    logic                RX_VALID;
    logic                RX_READY;
    logic                RX_OVERRUN;
    logic                OVR_CLR;
    logic                BUSY;

    modport master (
        output SCK, nSS, MOSI, TX_DATA, TX_VALID, RX_READY, OVR_CLR,
        input  MISO, MISO_OE, TX_READY, TX_UNDERRUN, RX_DATA, RX_VALID, RX_OVERRUN, BUSY
    );

    modport slave (
        input  SCK, nSS, MOSI, TX_DATA, TX_VALID, RX_READY, OVR_CLR,
        output MISO, MISO_OE, TX_READY, TX_UNDERRUN, RX_DATA, RX_VALID, RX_OVERRUN, BUSY
    );
endinterface

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - multi-stage pin synchroniser with rise/fall pulses
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= w_level;
        end
    end
endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target with one-deep TX holding register
// and an RX register with overrun tracking.
module spi_target
    import gt_spi_pkg::*;
#(
    parameter int                  SYNC_STAGES = 2,
    parameter logic [SPI_BITS-1:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
    input logic         CLK,
    input logic         RST,
    spi_target_if.slave bus
);
    localparam int              CW       = $clog2(SPI_BITS);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SPI_BITS - 1);

    spi_state_t            r_state;
    logic [CW-1:0]         r_count;
    logic [SPI_BITS-1:0]   r_tx_shift;
    logic [SPI_BITS-2:0]   r_rx_shift;
    logic [SPI_BITS-1:0]   r_hold;
    logic                  r_hold_full;
    logic [SPI_BITS-1:0]   r_rx_data;
    logic                  r_rx_valid;
    logic                  r_overrun;
    logic                  r_underrun;
    logic                  r_miso_oe;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic                  w_sck_rise;
    logic                  w_sck_fall;
    logic                  w_nss_rise;
    logic                  w_nss_fall;
    logic                  w_mosi;
    logic                  w_reload;
    logic                  w_byte_done;
    logic                  w_hold_load;
    logic [SPI_BITS-1:0]   w_load_byte;
    logic [SPI_BITS-1:0]   w_rx_next;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_pin (bus.SCK),
        .o_rise(w_sck_rise),
        .o_fall(w_sck_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_nss_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_pin (bus.nSS),
        .o_rise(w_nss_rise),
        .o_fall(w_nss_fall)
    );

    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_rx_next   = {r_rx_shift, w_mosi};
    assign w_load_byte = r_hold_full ? r_hold : IDLE_BYTE;
    assign w_hold_load = bus.TX_VALID && !r_hold_full;
    // A reload samples the holding register before any same-cycle load lands.
    assign w_reload    = ((r_state == ST_IDLE) && w_nss_fall) ||
                         ((r_state == ST_SHIFT) && !w_nss_rise && w_sck_fall && (r_count == '0));
    assign w_byte_done = (r_state == ST_SHIFT) && !w_nss_rise && w_sck_rise && (r_count == CNT_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
            r_underrun  <= w_reload && !r_hold_full;
            r_hold_full <= (r_hold_full && !w_reload) || w_hold_load;
            if (w_hold_load) begin
                r_hold <= bus.TX_DATA;
            end

            if (w_byte_done && (!r_rx_valid || bus.RX_READY)) begin
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && bus.RX_READY) begin
                r_rx_valid <= 1'b0;
            end
            r_overrun <= (r_overrun && !bus.OVR_CLR) ||
                         (w_byte_done && r_rx_valid && !bus.RX_READY);

            case (r_state)
                ST_IDLE: begin
                    if (w_nss_fall) begin
                        r_state    <= ST_SHIFT;
                        r_count    <= '0;
                        r_tx_shift <= w_load_byte;
                        r_miso_oe  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_nss_rise) begin
                        r_state   <= ST_IDLE;
                        r_count   <= '0;
                        r_miso_oe <= 1'b0;
                    end else if (w_sck_rise) begin
                        r_rx_shift <= w_rx_next[SPI_BITS-2:0];
                        r_count    <= r_count + CNT_ONE;
                    end else if (w_sck_fall) begin
                        if (r_count == '0) begin
                            r_tx_shift <= w_load_byte;
                        end else begin
                            r_tx_shift <= {r_tx_shift[SPI_BITS-2:0], 1'b0};
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.MISO        = r_miso_oe & r_tx_shift[SPI_BITS-1];
    assign bus.MISO_OE     = r_miso_oe;
    assign bus.TX_READY    = !r_hold_full;
    assign bus.TX_UNDERRUN = r_underrun;
    assign bus.RX_DATA     = r_rx_data;
    assign bus.RX_VALID    = r_rx_valid;
    assign bus.RX_OVERRUN  = r_overrun;
    assign bus.BUSY        = (r_state == ST_SHIFT) && (r_count != '0);
endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - directed self-checking bench for spi_target
module tb_spi_target;
    localparam int S = 2;
    localparam int H = S + 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    spi_target_if bus();

    spi_target #(.SYNC_STAGES(S), .IDLE_BYTE(8'hFF)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int urun_cnt = 0;

    always @(negedge CLK) begin
        if (bus.TX_UNDERRUN === 1'b1) urun_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic queue_byte(input logic [7:0] b);
        bus.TX_DATA  = b;
        bus.TX_VALID = 1'b1;
        clks(1);
        bus.TX_VALID = 1'b0;
    endtask

    task automatic select_dev();
        bus.nSS = 1'b0;
        clks(H);
    endtask

    task automatic deselect_dev();
        clks(H);
        bus.nSS = 1'b1;
        clks(H + 2);
    endtask

    task automatic xfer(input int nbits, input logic [7:0] mo, input int mid_at,
                        input logic [7:0] mid, output logic [7:0] mi, output int urun_snap);
        mi = 8'h00;
        urun_snap = 0;
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = mo[7-i];
            if (i == mid_at) begin
                bus.TX_DATA  = mid;
                bus.TX_VALID = 1'b1;
                clks(1);
                bus.TX_VALID = 1'b0;
                clks(H - 1);
            end else begin
                clks(H);
            end
            mi[7-i] = bus.MISO;
            bus.SCK = 1'b1;
            clks(H);
            if (i == nbits - 1) urun_snap = urun_cnt;
            bus.SCK = 1'b0;
        end
    endtask

    logic [7:0] mi;
    int         us;
    int         u0;
    logic [7:0] tx_stream [64];
    logic [7:0] rx_stream [64];

    initial begin
        bus.SCK = 1'b0; bus.nSS = 1'b1; bus.MOSI = 1'b0;
        bus.TX_DATA = 8'h00; bus.TX_VALID = 1'b0;
        bus.RX_READY = 1'b0; bus.OVR_CLR = 1'b0;
        clks(3);
        RST = 1'b0;
        clks(2);
        check_eq("rst_miso",     bus.MISO, 0);
        check_eq("rst_miso_oe",  bus.MISO_OE, 0);
        check_eq("rst_tx_ready", bus.TX_READY, 1);
        check_eq("rst_underrun", bus.TX_UNDERRUN, 0);
        check_eq("rst_rx_data",  bus.RX_DATA, 0);
        check_eq("rst_rx_valid", bus.RX_VALID, 0);
        check_eq("rst_overrun",  bus.RX_OVERRUN, 0);
        check_eq("rst_busy",     bus.BUSY, 0);

        // Basic byte: A5 out, 3C in
        queue_byte(8'hA5);
        check_eq("t1_tx_full", bus.TX_READY, 0);
        u0 = urun_cnt;
        select_dev();
        check_eq("t1_oe", bus.MISO_OE, 1);
        check_eq("t1_miso_first", bus.MISO, 1);
        xfer(8, 8'h3C, -1, 8'h00, mi, us);
        check_eq("t1_miso", mi, 8'hA5);
        check_eq("t1_no_underrun", us - u0, 0);
        check_eq("t1_rx_data", bus.RX_DATA, 8'h3C);
        check_eq("t1_rx_valid", bus.RX_VALID, 1);
        check_eq("t1_tx_ready", bus.TX_READY, 1);
        deselect_dev();
        bus.RX_READY = 1'b1;
        clks(1);
        bus.RX_READY = 1'b0;
        check_eq("t1_rx_consumed", bus.RX_VALID, 0);

        // Empty queue then mid-byte load
        u0 = urun_cnt;
        select_dev();
        check_eq("t2_underrun_sel", urun_cnt - u0, 1);
        bus.RX_READY = 1'b1;
        xfer(8, 8'h5A, 4, 8'h12, mi, us);
        check_eq("t2_miso_idle", mi, 8'hFF);
        check_eq("t2_underrun_b1", us - u0, 1);
        xfer(8, 8'hC3, -1, 8'h00, mi, us);
        check_eq("t2_miso_queued", mi, 8'h12);
        check_eq("t2_underrun_b2", us - u0, 1);
        check_eq("t2_rx_data", bus.RX_DATA, 8'hC3);
        deselect_dev();
        bus.RX_READY = 1'b0;
        check_eq("t2_rx_valid", bus.RX_VALID, 0);
        check_eq("t2_overrun", bus.RX_OVERRUN, 0);

        // Back-to-back with consumer stalled
        select_dev();
        xfer(8, 8'h01, -1, 8'h00, mi, us);
        xfer(8, 8'h02, -1, 8'h00, mi, us);
        check_eq("t3_rx_data", bus.RX_DATA, 8'h01);
        check_eq("t3_rx_valid", bus.RX_VALID, 1);
        check_eq("t3_overrun", bus.RX_OVERRUN, 1);
        deselect_dev();
        bus.OVR_CLR = 1'b1;
        clks(1);
        bus.OVR_CLR = 1'b0;
        check_eq("t3_ovr_clr", bus.RX_OVERRUN, 0);

        // Abort after 5 bits
        select_dev();
        xfer(5, 8'hE8, -1, 8'h00, mi, us);
        check_eq("t4_busy_mid", bus.BUSY, 1);
        deselect_dev();
        check_eq("t4_busy", bus.BUSY, 0);
        check_eq("t4_oe", bus.MISO_OE, 0);
        check_eq("t4_rx_valid", bus.RX_VALID, 1);
        check_eq("t4_rx_data", bus.RX_DATA, 8'h01);
        bus.RX_READY = 1'b1;
        clks(1);
        bus.RX_READY = 1'b0;
        queue_byte(8'h69);
        select_dev();
        check_eq("t4_miso_first", bus.MISO, 0);
        xfer(8, 8'h77, -1, 8'h00, mi, us);
        check_eq("t4_miso", mi, 8'h69);
        check_eq("t4_rx_clean", bus.RX_DATA, 8'h77);
        deselect_dev();

        // Reset mid-byte with holding register full
        queue_byte(8'h5E);
        select_dev();
        queue_byte(8'hA7);
        check_eq("t5_hold_full", bus.TX_READY, 0);
        xfer(3, 8'hFF, -1, 8'h00, mi, us);
        check_eq("t5_busy_pre", bus.BUSY, 1);
        RST = 1'b1;
        #1;
        check_eq("t5_miso",     bus.MISO, 0);
        check_eq("t5_oe",       bus.MISO_OE, 0);
        check_eq("t5_tx_ready", bus.TX_READY, 1);
        check_eq("t5_underrun", bus.TX_UNDERRUN, 0);
        check_eq("t5_rx_data",  bus.RX_DATA, 0);
        check_eq("t5_rx_valid", bus.RX_VALID, 0);
        check_eq("t5_overrun",  bus.RX_OVERRUN, 0);
        check_eq("t5_busy",     bus.BUSY, 0);
        bus.nSS = 1'b1;
        bus.SCK = 1'b0;
        clks(2);
        RST = 1'b0;
        clks(2);

        // Random stream at minimum half-period
        for (int k = 0; k < 64; k++) begin
            tx_stream[k] = 8'($urandom);
            rx_stream[k] = 8'($urandom);
        end
        bus.RX_READY = 1'b1;
        queue_byte(tx_stream[0]);
        select_dev();
        for (int k = 0; k < 64; k++) begin
            if (k < 63) xfer(8, rx_stream[k], 2, tx_stream[k+1], mi, us);
            else        xfer(8, rx_stream[k], -1, 8'h00, mi, us);
            check_eq("t6_miso", mi, tx_stream[k]);
            check_eq("t6_rx", bus.RX_DATA, rx_stream[k]);
        end
        deselect_dev();
        bus.RX_READY = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
